// File: rtl/exp_series_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : exp_ctrl_pkg                                               |
// | Description : Shared state encoding and default widths for the           |
// |               series-expansion (exp) controller.                         |
// | Options     : none (EXP_CTRL_ABORT_EN is consumed by the interface/top)  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package exp_ctrl_pkg;

  localparam int DEF_CNT_W      = 4;
  localparam int DEF_SEL_W      = 1;
  localparam int DEF_MULT_STEPS = 2;

  // Fixed 3-bit state encoding; the host may observe these codes on a debug
  // tap, so the values are pinned rather than left to the synthesizer.
  localparam logic [2:0] ST_IDLE_ENC = 3'd0;
  localparam logic [2:0] ST_LOAD_ENC = 3'd1;
  localparam logic [2:0] ST_INIT_ENC = 3'd2;
  localparam logic [2:0] ST_MULT_ENC = 3'd3;
  localparam logic [2:0] ST_ADD_ENC  = 3'd4;
  localparam logic [2:0] ST_DONE_ENC = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_LOAD = ST_LOAD_ENC,
    ST_INIT = ST_INIT_ENC,
    ST_MULT = ST_MULT_ENC,
    ST_ADD  = ST_ADD_ENC,
    ST_DONE = ST_DONE_ENC
  } state_e;

endpackage
`default_nettype wire

// File: rtl/exp_series_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface   : exp_series_ctrl_if                                         |
// | Description : Host handshake plus datapath control strobes of the exp    |
// |               series controller.                                         |
// |   master : drives start, n_terms (and abort); observes everything else   |
// |   slave  : the controller; drives busy/done, zx/zt/zc, ldx, initt/initr, |
// |            ldt/ldr, enc, sel, term_idx (and aborted)                     |
// | Options     : EXP_CTRL_ABORT_EN adds abort (in) / aborted (out)          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface exp_series_ctrl_if
  import exp_ctrl_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int SEL_W = DEF_SEL_W
) ();

  logic             start;
  logic [CNT_W-1:0] n_terms;
  logic             busy;
  logic             done;
  logic             zx;
  logic             zt;
  logic             zc;
  logic             ldx;
  logic             initt;
  logic             initr;
  logic             ldt;
  logic             ldr;
  logic             enc;
  logic [SEL_W-1:0] sel;
  logic [CNT_W-1:0] term_idx;
`ifdef EXP_CTRL_ABORT_EN
  logic             abort;
  logic             aborted;

  modport master (
    output start, n_terms, abort,
    input  busy, done, zx, zt, zc, ldx, initt, initr, ldt, ldr, enc, sel,
           term_idx, aborted
  );

  modport slave (
    input  start, n_terms, abort,
    output busy, done, zx, zt, zc, ldx, initt, initr, ldt, ldr, enc, sel,
           term_idx, aborted
  );
`else
  modport master (
    output start, n_terms,
    input  busy, done, zx, zt, zc, ldx, initt, initr, ldt, ldr, enc, sel,
           term_idx
  );

  modport slave (
    input  start, n_terms,
    output busy, done, zx, zt, zc, ldx, initt, initr, ldt, ldr, enc, sel,
           term_idx
  );
`endif

endinterface
`default_nettype wire

// File: rtl/exp_series_ctrl_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : exp_ctrl_cnt                                               |
// | Description : Term counter for the exp controller. Synchronous clear has |
// |               priority over increment; wraps modulo 2**CNT_W.            |
// |   clk     in  clock, rising edge                                         |
// |   rst     in  synchronous active-low reset                               |
// |   clr_i   in  clear to zero                                              |
// |   inc_i   in  increment                                                  |
// |   lim_i   in  number of terms of the current run                         |
// |   cnt_o   out current count                                              |
// |   last_o  out count equals lim_i-1 (last term in progress)               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module exp_ctrl_cnt #(
  parameter int CNT_W = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             clr_i,
  input  wire logic             inc_i,
  input  wire logic [CNT_W-1:0] lim_i,
  output logic      [CNT_W-1:0] cnt_o,
  output logic                  last_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o  = cnt_q;
  // Only meaningful for lim_i >= 1; a zero-term run never reaches ADD.
  assign last_o = (cnt_q == (lim_i - 1'b1));

endmodule
`default_nettype wire

// File: rtl/exp_series_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : exp_series_ctrl                                            |
// | Description : Moore FSM sequencing the exp series datapath: loads x,     |
// |               presets term/result, then per term runs MULT_STEPS         |
// |               multiply cycles followed by one accumulate cycle.          |
// |   clk      in  clock, rising edge                                        |
// |   rst      in  synchronous active-low reset                              |
// |   ctrl_if  slave modport of exp_series_ctrl_if (host + datapath strobes) |
// | Parameters  : CNT_W (term width), MULT_STEPS (>=1), SEL_W               |
// |               (2**SEL_W >= MULT_STEPS)                                   |
// | Options     : EXP_CTRL_ABORT_EN - abort input ends a run early          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module exp_series_ctrl
  import exp_ctrl_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int MULT_STEPS = DEF_MULT_STEPS,
  parameter int SEL_W      = DEF_SEL_W
) (
  input  wire logic        clk,
  input  wire logic        rst,
  exp_series_ctrl_if.slave ctrl_if
);

  localparam logic [SEL_W-1:0] LAST_STEP = SEL_W'(MULT_STEPS - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] step_q, step_d;
  logic [CNT_W-1:0] n_q, n_d;
  // Set when start is still high as DONE exits; a new run needs start low first.
  logic             rearm_q, rearm_d;

  logic             busy_q, done_q, zx_q, zt_q, zc_q, ldx_q;
  logic             initt_q, initr_q, ldt_q, ldr_q, enc_q;
  logic [SEL_W-1:0] sel_q;

  logic             w_abort;
  logic             w_go_abort;
  logic             w_cnt_clr;
  logic             w_cnt_inc;
  logic             w_term_last;
  logic [CNT_W-1:0] w_term_cnt;

`ifdef EXP_CTRL_ABORT_EN
  logic             aborted_q;
  assign w_abort = ctrl_if.abort;
`else
  assign w_abort = 1'b0;
`endif

  // Abort only matters while the datapath is actually computing.
  assign w_go_abort = w_abort &&
                      ((state_q == ST_INIT) || (state_q == ST_MULT) ||
                       (state_q == ST_ADD));

  assign w_cnt_clr = (state_q == ST_INIT);
  assign w_cnt_inc = (state_q == ST_ADD) && !w_go_abort;

  exp_ctrl_cnt #(
    .CNT_W (CNT_W)
  ) u_term_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (w_cnt_clr),
    .inc_i  (w_cnt_inc),
    .lim_i  (n_q),
    .cnt_o  (w_term_cnt),
    .last_o (w_term_last)
  );

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    n_d     = n_q;
    rearm_d = rearm_q;
    if (w_go_abort) begin
      state_d = ST_DONE;
      step_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!ctrl_if.start) begin
            rearm_d = 1'b0;
          end else if (!rearm_q) begin
            state_d = ST_LOAD;
            n_d     = ctrl_if.n_terms;
          end
        end
        ST_LOAD: begin
          if (!ctrl_if.start) begin
            state_d = ST_INIT;
          end
        end
        ST_INIT: begin
          step_d  = '0;
          state_d = (n_q == '0) ? ST_DONE : ST_MULT;
        end
        ST_MULT: begin
          if (step_q == LAST_STEP) begin
            state_d = ST_ADD;
            step_d  = '0;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
        ST_ADD: begin
          state_d = w_term_last ? ST_DONE : ST_MULT;
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          rearm_d = ctrl_if.start;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they are registered yet line
  // up with the state they belong to.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      step_q    <= '0;
      n_q       <= '0;
      rearm_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      zx_q      <= 1'b1;
      zt_q      <= 1'b1;
      zc_q      <= 1'b1;
      ldx_q     <= 1'b0;
      initt_q   <= 1'b0;
      initr_q   <= 1'b0;
      ldt_q     <= 1'b0;
      ldr_q     <= 1'b0;
      enc_q     <= 1'b0;
      sel_q     <= '0;
`ifdef EXP_CTRL_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      n_q       <= n_d;
      rearm_q   <= rearm_d;
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= (state_d == ST_DONE);
      zx_q      <= (state_d == ST_IDLE);
      zt_q      <= (state_d == ST_IDLE);
      zc_q      <= (state_d == ST_IDLE);
      ldx_q     <= (state_d == ST_LOAD);
      initt_q   <= (state_d == ST_INIT);
      initr_q   <= (state_d == ST_INIT);
      ldt_q     <= (state_d == ST_MULT);
      ldr_q     <= (state_d == ST_ADD);
      enc_q     <= (state_d == ST_ADD);
      sel_q     <= (state_d == ST_MULT) ? step_d : '0;
`ifdef EXP_CTRL_ABORT_EN
      aborted_q <= w_go_abort;
`endif
    end
  end

  assign ctrl_if.busy     = busy_q;
  assign ctrl_if.done     = done_q;
  assign ctrl_if.zx       = zx_q;
  assign ctrl_if.zt       = zt_q;
  assign ctrl_if.zc       = zc_q;
  assign ctrl_if.ldx      = ldx_q;
  assign ctrl_if.initt    = initt_q;
  assign ctrl_if.initr    = initr_q;
  assign ctrl_if.ldt      = ldt_q;
  // An abort seen during ADD must not commit the accumulate or the count.
  assign ctrl_if.ldr      = ldr_q & ~w_go_abort;
  assign ctrl_if.enc      = enc_q & ~w_go_abort;
  assign ctrl_if.sel      = sel_q;
  assign ctrl_if.term_idx = w_term_cnt;
`ifdef EXP_CTRL_ABORT_EN
  assign ctrl_if.aborted  = aborted_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_exp_series_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_exp_series_ctrl                                         |
// | Description : Self-checking bench for exp_series_ctrl. DUT A uses the    |
// |               defaults (MULT_STEPS=2, SEL_W=1), DUT B uses MULT_STEPS=3, |
// |               SEL_W=2. Expected per-cycle strobes come from a trace of   |
// |               the run (INIT, per term MULT steps + ADD, DONE).           |
// | Options     : EXP_CTRL_ABORT_EN enables the abort scenario               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_exp_series_ctrl;

  localparam int K_IDLE  = 0;
  localparam int K_LOAD  = 1;
  localparam int K_INIT  = 2;
  localparam int K_MULT  = 3;
  localparam int K_ADD   = 4;
  localparam int K_DONE  = 5;
  localparam int K_ADDAB = 6;  // ADD cycle cancelled by abort: only busy

  typedef struct {
    int kind;
    int s;
    int idx;
  } row_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   mdl_idx[2];

  always #5 clk = ~clk;

  exp_series_ctrl_if #(.CNT_W(4), .SEL_W(1)) if_a ();
  exp_series_ctrl_if #(.CNT_W(4), .SEL_W(2)) if_b ();

  exp_series_ctrl #(.CNT_W(4), .MULT_STEPS(2), .SEL_W(1)) dut_a (
    .clk     (clk),
    .rst     (rst),
    .ctrl_if (if_a.slave)
  );

  exp_series_ctrl #(.CNT_W(4), .MULT_STEPS(3), .SEL_W(2)) dut_b (
    .clk     (clk),
    .rst     (rst),
    .ctrl_if (if_b.slave)
  );

  logic [16:0] obs_a, obs_b;
  assign obs_a = {if_a.busy, if_a.done, if_a.zx, if_a.zt, if_a.zc, if_a.ldx,
                  if_a.initt, if_a.initr, if_a.ldt, if_a.ldr, if_a.enc,
                  1'b0, if_a.sel, if_a.term_idx};
  assign obs_b = {if_b.busy, if_b.done, if_b.zx, if_b.zt, if_b.zc, if_b.ldx,
                  if_b.initt, if_b.initr, if_b.ldt, if_b.ldr, if_b.enc,
                  if_b.sel, if_b.term_idx};

  function automatic logic [16:0] row(input int kind, input int s, input int idx);
    logic [16:0] v;
    v       = '0;
    v[16]   = (kind != K_IDLE);
    v[15]   = (kind == K_DONE);
    v[14]   = (kind == K_IDLE);
    v[13]   = (kind == K_IDLE);
    v[12]   = (kind == K_IDLE);
    v[11]   = (kind == K_LOAD);
    v[10]   = (kind == K_INIT);
    v[9]    = (kind == K_INIT);
    v[8]    = (kind == K_MULT);
    v[7]    = (kind == K_ADD);
    v[6]    = (kind == K_ADD);
    v[5:4]  = (kind == K_MULT) ? 2'(s) : 2'd0;
    v[3:0]  = 4'(idx);
    return v;
  endfunction

  function automatic logic [16:0] get_obs(input int which);
    return (which == 0) ? obs_a : obs_b;
  endfunction

  task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] want);
    n_checks++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int want);
    n_checks++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  task automatic set_start(input int which, input logic v);
    if (which == 0) if_a.start = v;
    else            if_b.start = v;
  endtask

  task automatic set_n(input int which, input int v);
    if (which == 0) if_a.n_terms = 4'(v);
    else            if_b.n_terms = 4'(v);
  endtask

  // One complete run on DUT 'which'; called at a negedge with the DUT idle.
  task automatic run(input int which, input int n, input int hold,
                     input bit keep_high, input string tag);
    int          m;
    int          old;
    int          ldt_cnt;
    int          enc_cnt;
    int          lat;
    int          fin;
    logic [16:0] o;
    row_t        q[$];
    m       = (which == 0) ? 2 : 3;
    old     = mdl_idx[which];
    ldt_cnt = 0;
    enc_cnt = 0;
    lat     = -1;
    fin     = (n == 0) ? 0 : (n % 16);
    chk({tag, ":idle_pre"}, get_obs(which), row(K_IDLE, 0, old));
    set_n(which, n);
    set_start(which, 1'b1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, ":load"}, get_obs(which), row(K_LOAD, 0, old));
      set_n(which, int'($urandom_range(0, 15)));  // must be ignored now
    end
    set_start(which, 1'b0);
    q.push_back('{K_INIT, 0, old});
    for (int t = 0; t < n; t++) begin
      for (int s = 0; s < m; s++) q.push_back('{K_MULT, s, t});
      q.push_back('{K_ADD, 0, t});
    end
    q.push_back('{K_DONE, 0, fin});
    for (int k = 0; k < q.size(); k++) begin
      @(negedge clk);
      o = get_obs(which);
      chk({tag, ":trace"}, o, row(q[k].kind, q[k].s, q[k].idx));
      if (o[8]) ldt_cnt++;
      if (o[6]) enc_cnt++;
      if (o[15] && lat < 0) lat = k + 1;
      if (k == 0 && keep_high) set_start(which, 1'b1);
    end
    chk_int({tag, ":latency"}, lat, 1 + n * (m + 1) + 1);
    chk_int({tag, ":ldt_cnt"}, ldt_cnt, n * m);
    chk_int({tag, ":enc_cnt"}, enc_cnt, n);
    if (keep_high) begin
      for (int h = 0; h < 3; h++) begin
        @(negedge clk);
        chk({tag, ":no_rerun"}, get_obs(which), row(K_IDLE, 0, fin));
      end
      set_start(which, 1'b0);
    end
    @(negedge clk);
    chk({tag, ":idle_post"}, get_obs(which), row(K_IDLE, 0, fin));
    mdl_idx[which] = fin;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    if_a.start = 1'b0; if_a.n_terms = '0;
    if_b.start = 1'b0; if_b.n_terms = '0;
`ifdef EXP_CTRL_ABORT_EN
    if_a.abort = 1'b0;
    if_b.abort = 1'b0;
`endif
    mdl_idx[0] = 0;
    mdl_idx[1] = 0;

    // Reset state, including a start request ignored while in reset.
    repeat (3) @(negedge clk);
    chk("reset_a", obs_a, row(K_IDLE, 0, 0));
    chk("reset_b", obs_b, row(K_IDLE, 0, 0));
    if_a.start = 1'b1;
    @(negedge clk);
    chk("reset_start_a", obs_a, row(K_IDLE, 0, 0));
    if_a.start = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    // Directed runs.
    run(0, 3, 2, 1'b0, "t1_n3");
    run(0, 0, 1, 1'b0, "t2_n0");
    run(1, 2, 1, 1'b0, "t3_m3");

    // Reset during the second MULT of a 5-term run.
    chk("t4_idle_pre", obs_a, row(K_IDLE, 0, mdl_idx[0]));
    if_a.n_terms = 4'd5;
    if_a.start   = 1'b1;
    @(negedge clk);
    chk("t4_load", obs_a, row(K_LOAD, 0, mdl_idx[0]));
    if_a.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t4_mult0", obs_a, row(K_MULT, 0, 0));
    @(negedge clk);
    chk("t4_mult1", obs_a, row(K_MULT, 1, 0));
    rst = 1'b0;
    @(negedge clk);
    chk("t4_rst_a", obs_a, row(K_IDLE, 0, 0));
    chk("t4_rst_b", obs_b, row(K_IDLE, 0, 0));
    rst = 1'b1;
    mdl_idx[0] = 0;
    mdl_idx[1] = 0;
    @(negedge clk);
    run(0, 5, 1, 1'b0, "t4_rerun");

    // start held high through DONE.
    run(0, 2, 1, 1'b1, "t5_hold");

    // Maximum-length run and randomized runs on both DUTs.
    run(1, 15, 1, 1'b0, "max_n15");
    for (int r = 0; r < 10; r++) begin
      run(int'($urandom_range(0, 1)), int'($urandom_range(0, 6)),
          int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), "rand");
    end

`ifdef EXP_CTRL_ABORT_EN
    // Abort during the first ADD of a 4-term run.
    begin
      int enc_cnt;
      enc_cnt = 0;
      chk("t6_idle_pre", obs_a, row(K_IDLE, 0, mdl_idx[0]));
      if_a.n_terms = 4'd4;
      if_a.start   = 1'b1;
      @(negedge clk);
      chk("t6_load", obs_a, row(K_LOAD, 0, mdl_idx[0]));
      if_a.start = 1'b0;
      @(negedge clk);
      chk("t6_init", obs_a, row(K_INIT, 0, mdl_idx[0]));
      @(negedge clk);
      chk("t6_mult0", obs_a, row(K_MULT, 0, 0));
      @(negedge clk);
      chk("t6_mult1", obs_a, row(K_MULT, 1, 0));
      @(posedge clk);
      #1 if_a.abort = 1'b1;
      @(negedge clk);
      if (obs_a[6]) enc_cnt++;
      chk("t6_add_masked", obs_a, row(K_ADDAB, 0, 0));
      @(posedge clk);
      #1 if_a.abort = 1'b0;
      @(negedge clk);
      if (obs_a[6]) enc_cnt++;
      chk("t6_done", obs_a, row(K_DONE, 0, 0));
      chk_int("t6_aborted", int'(if_a.aborted), 1);
      @(negedge clk);
      chk("t6_idle_post", obs_a, row(K_IDLE, 0, 0));
      chk_int("t6_aborted_clr", int'(if_a.aborted), 0);
      chk_int("t6_enc_cnt", enc_cnt, 0);
      mdl_idx[0] = 0;
      run(0, 2, 1, 1'b0, "t6_after");
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
